// File: rtl/decoder_rr_arbiter.sv
// ============================================================================
// decoder_rr_arbiter
//
// Round-robin arbiter for 8 requesters that share one decoded (3-to-8 one-hot)
// select. The winner index and its one-hot decode are registered outputs.
// A grant stays with its owner until the owner drops its request, the arbiter
// is disabled, or the owner has held it for MAX_HOLD consecutive cycles. After
// MAX_HOLD cycles the arbiter searches again and pulses TIMEOUT.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles per owner (>= 1)
//
// Ports
//   CLK      in   1  clock; all state changes on posedge CLK
//   RST      in   1  synchronous, active-high reset
//   EN       in   1  arbiter enable; low forces the grant off
//   REQ      in   8  request vector, bit i = requester i
//   GNT      out  8  one-hot decode of GNT_IDX while VALID, else 8'h00
//   GNT_IDX  out  3  index of the current grantee; holds last value when idle
//   VALID    out  1  a grant is active
//   TIMEOUT  out  1  one-cycle pulse when a grant ends because MAX_HOLD expired
//
// Build option
//   DECODER_ARB_GAP_EN  when defined, every grant end (release or expiry)
//                       is followed by exactly one cycle with no grant (GAP
//                       state) before the next grant. When undefined, the
//                       handover is back-to-back.
// ============================================================================
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic [2:0] GNT_IDX,
    output logic       VALID,
    output logic       TIMEOUT
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [2:0]         ptr_reg, ptr_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;
    logic [2:0]         idx_reg, idx_next;
    logic               valid_reg, valid_next;
    logic               timeout_reg, timeout_next;
    logic [7:0]         gnt_reg, gnt_next;

    // ------------------------------------------------------------------
    // Round-robin search. rot_req[k] is the request of index base+k+1
    // (3-bit wrap), so the lowest set bit of rot_req is the winner and
    // the base index itself is considered last (k = 7).
    // While granting, the base is the current grantee: at a release or an
    // expiry the pointer becomes the grantee, and the same-cycle search
    // has to see that updated pointer.
    // ------------------------------------------------------------------
    logic [2:0] search_base;
    logic [7:0] rot_req;
    logic       search_hit;
    logic [2:0] search_off;
    logic [2:0] winner;

    assign search_base = (state_reg == GRANT) ? idx_reg : ptr_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            localparam logic [2:0] OFF = 3'(gi + 1);
            assign rot_req[gi] = REQ[3'(search_base + OFF)];
        end
    endgenerate

    always_comb begin
        search_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_req[k]) begin
                search_off = 3'(k);
            end
        end
    end

    assign search_hit = |rot_req;
    assign winner     = 3'(search_base + search_off + 3'd1);

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;
        idx_next     = idx_reg;
        valid_next   = valid_reg;
        timeout_next = 1'b0;

        case (state_reg)
            IDLE: begin
                valid_next = 1'b0;
                if (EN && search_hit) begin
                    idx_next   = winner;
                    valid_next = 1'b1;
                    hold_next  = '0;
                    state_next = GRANT;
                end
            end

            GRANT: begin
                if (!EN) begin
                    valid_next = 1'b0;
                    ptr_next   = idx_reg;
                    state_next = IDLE;
                end else if (!REQ[idx_reg]) begin
                    // Release takes precedence over a coincident expiry.
                    ptr_next = idx_reg;
`ifdef DECODER_ARB_GAP_EN
                    valid_next = 1'b0;
                    state_next = GAP;
`else
                    if (search_hit) begin
                        idx_next  = winner;
                        hold_next = '0;
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
`endif
                end else if (hold_reg == HOLD_LAST) begin
                    timeout_next = 1'b1;
                    ptr_next     = idx_reg;
`ifdef DECODER_ARB_GAP_EN
                    valid_next = 1'b0;
                    state_next = GAP;
`else
                    // The owner still requests, so the search always hits;
                    // it finds the owner only when nobody else is asking.
                    idx_next  = winner;
                    hold_next = '0;
`endif
                end else begin
                    hold_next = hold_reg + HOLD_W'(1);
                end
            end

`ifdef DECODER_ARB_GAP_EN
            GAP: begin
                if (EN && search_hit) begin
                    idx_next   = winner;
                    valid_next = 1'b1;
                    hold_next  = '0;
                    state_next = GRANT;
                end else begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
`endif

            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // One-hot decode of the next index, gated by the next valid, so the
    // registered GNT can never have more than one bit set.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign gnt_next[gi] = valid_next && (idx_next == 3'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            ptr_reg     <= 3'd7;
            hold_reg    <= '0;
            idx_reg     <= 3'd0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            gnt_reg     <= 8'h00;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            idx_reg     <= idx_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
            gnt_reg     <= gnt_next;
        end
    end

    assign GNT     = gnt_reg;
    assign GNT_IDX = idx_reg;
    assign VALID   = valid_reg;
    assign TIMEOUT = timeout_reg;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// ============================================================================
// tb_decoder_rr_arbiter
//
// Directed bench for decoder_rr_arbiter (MAX_HOLD = 4, back-to-back build).
// Each stimulus step drives inputs shortly after a falling edge and pushes
// the hand-computed outputs expected after the next rising edge. A separate
// monitor pops one expectation per falling edge and compares.
// ============================================================================
module tb_decoder_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       valid;
    logic       timeout;

    decoder_rr_arbiter #(
        .MAX_HOLD(4)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .EN     (en),
        .REQ    (req),
        .GNT    (gnt),
        .GNT_IDX(gnt_idx),
        .VALID  (valid),
        .TIMEOUT(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    bit   mon_en       = 1'b0;

    // Monitor: one expectation per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (gnt !== e.gnt || gnt_idx !== e.idx || valid !== e.valid ||
                timeout !== e.timeout) begin
                tests_failed++;
                $display("FAIL %s: got gnt=%02h idx=%0d valid=%0b timeout=%0b, expected gnt=%02h idx=%0d valid=%0b timeout=%0b",
                         e.name, gnt, gnt_idx, valid, timeout,
                         e.gnt, e.idx, e.valid, e.timeout);
            end else begin
                $display("[TB] %s: gnt=%02h idx=%0d valid=%0b timeout=%0b ok",
                         e.name, gnt, gnt_idx, valid, timeout);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input string name, input logic r, input logic e,
                        input logic [7:0] rq, input logic [7:0] x_gnt,
                        input logic [2:0] x_idx, input logic x_valid,
                        input logic x_to);
        exp_t x;
        @(negedge clk);
        #1;
        rst = r;
        en  = e;
        req = rq;
        x.name    = name;
        x.gnt     = x_gnt;
        x.idx     = x_idx;
        x.valid   = x_valid;
        x.timeout = x_to;
        exp_q.push_back(x);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        req = 8'hFF;
        mon_en = 1'b1;

        // 1. Reset held with all requests, then first grant goes to 0.
        for (int i = 0; i < 3; i++) step("reset", 1, 1, 8'hFF, 8'h00, 3'd0, 0, 0);
        step("first_grant", 0, 1, 8'hFF, 8'h01, 3'd0, 1, 0);

        // 2. Rotation between requesters 2 and 5 (idx 0 releases first).
        step("rot_release", 0, 1, 8'h24, 8'h04, 3'd2, 1, 0);
        for (int i = 0; i < 3; i++) step("rot_hold2", 0, 1, 8'h24, 8'h04, 3'd2, 1, 0);
        step("rot_to5", 0, 1, 8'h24, 8'h20, 3'd5, 1, 1);
        for (int i = 0; i < 3; i++) step("rot_hold5", 0, 1, 8'h24, 8'h20, 3'd5, 1, 0);
        step("rot_to2", 0, 1, 8'h24, 8'h04, 3'd2, 1, 1);
        for (int i = 0; i < 3; i++) step("rot_hold2b", 0, 1, 8'h24, 8'h04, 3'd2, 1, 0);

        // 3. Sole requester 7: release and expiry coincide on the first
        //    step (release wins, no pulse), then re-granted every 4 cycles.
        step("sole_release", 0, 1, 8'h80, 8'h80, 3'd7, 1, 0);
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 3; i++) step("sole_hold", 0, 1, 8'h80, 8'h80, 3'd7, 1, 0);
            step("sole_expire", 0, 1, 8'h80, 8'h80, 3'd7, 1, 1);
        end
        for (int i = 0; i < 3; i++) step("sole_hold", 0, 1, 8'h80, 8'h80, 3'd7, 1, 0);

        // 4. Wrap: 7 drops with 8'h41 pending at hold limit -> 0, no idle.
        step("wrap", 0, 1, 8'h41, 8'h01, 3'd0, 1, 0);

        // 5. EN drop while 2 granted, then resume from pointer 2.
        step("en_pre", 0, 1, 8'h0C, 8'h04, 3'd2, 1, 0);
        step("en_drop", 0, 0, 8'h0C, 8'h00, 3'd2, 0, 0);
        step("en_low", 0, 0, 8'h0C, 8'h00, 3'd2, 0, 0);
        step("en_resume", 0, 1, 8'h0C, 8'h08, 3'd3, 1, 0);

        // 6. Reset mid-grant of requester 4.
        step("mid_pre", 0, 1, 8'h11, 8'h10, 3'd4, 1, 0);
        step("mid_reset", 1, 1, 8'h11, 8'h00, 3'd0, 0, 0);
        step("post_reset", 0, 1, 8'h11, 8'h01, 3'd0, 1, 0);
        for (int i = 0; i < 3; i++) step("post_hold", 0, 1, 8'h11, 8'h01, 3'd0, 1, 0);
        step("post_expire", 0, 1, 8'h11, 8'h10, 3'd4, 1, 1);

        // Release with nothing pending, idle quiet, EN low blocks requests.
        step("release_idle", 0, 1, 8'h00, 8'h00, 3'd4, 0, 0);
        step("idle_quiet", 0, 1, 8'h00, 8'h00, 3'd4, 0, 0);
        step("idle_en_low", 0, 0, 8'hFF, 8'h00, 3'd4, 0, 0);
        step("idle_regrant", 0, 1, 8'h08, 8'h08, 3'd3, 1, 0);

        // Let the monitor drain the last expectation.
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
